spu_operand_fetch: RTL

//  Register-file initiator for the SPU datapath. Accepts decoded instructions over valid/ready.

---
 rtl/spu_operand_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/spu_operand_fetch.sv
// spu_operand_fetch
// Operand-fetch stage for the SPU datapath. Accepts decoded instructions,
// reads the 2R1W register file, tracks in-flight writebacks in a busy
// scoreboard, stalls on RAW/WAW hazards and hands registered operands to the
// ALU through a one-entry output slot.
// Optional feature: define WB_BYPASS_EN to let an instruction that depends on
// a register being written back in the current cycle issue in that same cycle,
// taking the writeback data directly instead of the (stale) RF data.
module spu_operand_fetch #(
    parameter int DEPTH = 16,
    parameter int ADDR  = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ADDR-1:0]  in_rs1,
    input  logic [ADDR-1:0]  in_rs2,
    input  logic             in_use1,
    input  logic             in_use2,
    input  logic [ADDR-1:0]  in_rd,
    input  logic             in_wb,
    output logic             rf_r1_en,
    output logic [ADDR-1:0]  rf_r1_addr,
    input  logic [WIDTH-1:0] rf_r1_data,
    output logic             rf_r2_en,
    output logic [ADDR-1:0]  rf_r2_addr,
    input  logic [WIDTH-1:0] rf_r2_data,
    output logic             rf_w_en,
    output logic [ADDR-1:0]  rf_w_addr,
    output logic [WIDTH-1:0] rf_w_data,
    input  logic             wb_valid,
    input  logic [ADDR-1:0]  wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_op1,
    output logic [WIDTH-1:0] out_op2,
    output logic [ADDR-1:0]  out_rd,
    output logic             out_wb,
    output logic             wb_err,
    output logic [15:0]      stall_cnt
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] wb_clr;
    logic [DEPTH-1:0] busy_eff;
    logic             hazard;
    logic             slot_free;
    logic             accept;
    logic             stall_cycle;
    logic [WIDTH-1:0] op1_src;
    logic [WIDTH-1:0] op2_src;

    // Read ports follow the incoming instruction; the write port passes the
    // ALU writeback straight through to the register file.
    assign rf_r1_en   = in_valid & in_use1;
    assign rf_r1_addr = in_rs1;
    assign rf_r2_en   = in_valid & in_use2;
    assign rf_r2_addr = in_rs2;
    assign rf_w_en    = wb_valid;
    assign rf_w_addr  = wb_addr;
    assign rf_w_data  = wb_data;

    // One-hot mask of the register being written back this cycle, and the busy
    // view used for hazard detection (writebacks in flight hide their bit only
    // when the bypass path can supply the data).
    always_comb begin
        wb_clr = '0;
        if (wb_valid) begin
            wb_clr[wb_addr] = 1'b1;
        end
`ifdef WB_BYPASS_EN
        busy_eff = busy & ~wb_clr;
`else
        busy_eff = busy;
`endif
    end

    // Operand selection: RF data, or the same-cycle writeback data when bypassing.
    always_comb begin
        op1_src = rf_r1_data;
        op2_src = rf_r2_data;
`ifdef WB_BYPASS_EN
        if (wb_valid && (wb_addr == in_rs1)) begin
            op1_src = wb_data;
        end
        if (wb_valid && (wb_addr == in_rs2)) begin
            op2_src = wb_data;
        end
`endif
    end

    assign hazard      = (in_use1 & busy_eff[in_rs1])
                       | (in_use2 & busy_eff[in_rs2])
                       | (in_wb   & busy_eff[in_rd]);
    assign slot_free   = ~out_valid | out_ready;
    assign in_ready    = ~hazard & slot_free;
    assign accept      = in_valid & in_ready;
    assign stall_cycle = in_valid & hazard & slot_free;

    // Output slot: load on accept, drain when the ALU takes it, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_wb    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op1   <= in_use1 ? op1_src : '0;
            out_op2   <= in_use2 ? op2_src : '0;
            out_rd    <= in_rd;
            out_wb    <= in_wb;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Scoreboard: writebacks clear their bit, an accepted writer sets its bit,
    // and a set overrides a clear of the same register in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~wb_clr) | ((accept && in_wb) ? (DEPTH'(1) << in_rd) : '0);
        end
    end

    // Flag a writeback that targets a register nobody was waiting on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else begin
            wb_err <= wb_valid & ~busy[wb_addr];
        end
    end

    // Count cycles lost purely to hazards, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_cycle && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
